// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - buffers fetched instructions and issues ALU op/funct fields in order, stopping at HALT
// Optional feature: define DECODE_ERR_EN to add the err output flagging unsupported ops at the head.
module alu_op_issue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  ALU_op,
  output logic [1:0]  ALU_funct,
  output logic        op_valid,
  input  logic        op_ready,
`ifdef DECODE_ERR_EN
  output logic        err,
`endif
  output logic        halted
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t          state, state_nxt;
  logic [6:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [6:0]      head;
  logic            push, pop;

  assign head        = mem[rd_ptr];
  assign ALU_op      = head[6:2];
  assign ALU_funct   = head[1:0];
  assign instr_ready = (state == RUN) && (count < CW'(DEPTH));
  assign op_valid    = (count != '0) && (state != HALTED);
  assign halted      = (state == HALTED);
  assign push        = instr_valid && instr_ready;
  assign pop         = op_valid && op_ready;

`ifdef DECODE_ERR_EN
  logic supported;
  always_comb begin
    supported = 1'b0;
    case (head[6:2])
      5'b11011: supported = (head[1:0] == 2'b00) || (head[1:0] == 2'b11);
      5'b01000, 5'b11000, 5'b00000: supported = 1'b1;
      default:  supported = 1'b0;
    endcase
  end
  assign err = op_valid && !supported;
`endif

  // HALT is always the last op in the buffer, so popping an opcode of zero in DRAIN ends the stream.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (push && instr[15:11] == 5'b00000) state_nxt = DRAIN;
      DRAIN:   if (pop && head[6:2] == 5'b00000) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (push) begin
        mem[wr_ptr] <= {instr[15:11], instr[1:0]};
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - randomized self-checking bench for alu_op_issue against a queue model
module tb_alu_op_issue;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  ALU_op;
  logic [1:0]  ALU_funct;
  logic        op_valid;
  logic        op_ready;
  logic        halted;
`ifdef DECODE_ERR_EN
  logic        err;
`endif

  int compared = 0;
  int mismatched = 0;

  logic [6:0] q[$];
  bit m_drain, m_halted;

  alu_op_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ALU_op(ALU_op), .ALU_funct(ALU_funct),
    .op_valid(op_valid), .op_ready(op_ready),
`ifdef DECODE_ERR_EN
    .err(err),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic bit supported(input logic [6:0] e);
    if (e[6:2] == 5'b11011) return (e[1:0] == 2'b00) || (e[1:0] == 2'b11);
    return (e[6:2] == 5'b01000) || (e[6:2] == 5'b11000) || (e[6:2] == 5'b00000);
  endfunction

  // Called at a falling edge: checks outputs against the model, drives inputs, advances one clock.
  task automatic step(input logic v, input logic [15:0] i, input logic r);
    logic m_ready, m_valid, push, pop;
    logic [6:0] popped;
    m_ready = !m_drain && !m_halted && (q.size() < DEPTH);
    m_valid = (q.size() != 0) && !m_halted;
    instr_valid = v; instr = i; op_ready = r;
    compared++;
    if (instr_ready !== m_ready) begin
      mismatched++; $display("FAIL instr_ready: got %b expected %b", instr_ready, m_ready);
    end
    compared++;
    if (op_valid !== m_valid) begin
      mismatched++; $display("FAIL op_valid: got %b expected %b", op_valid, m_valid);
    end
    compared++;
    if (halted !== m_halted) begin
      mismatched++; $display("FAIL halted: got %b expected %b", halted, m_halted);
    end
    if (m_valid) begin
      compared++;
      if ({ALU_op, ALU_funct} !== q[0]) begin
        mismatched++; $display("FAIL head_op: got %b_%b expected %b_%b", ALU_op, ALU_funct, q[0][6:2], q[0][1:0]);
      end
`ifdef DECODE_ERR_EN
      compared++;
      if (err !== !supported(q[0])) begin
        mismatched++; $display("FAIL err: got %b expected %b", err, !supported(q[0]));
      end
`endif
    end
    push = v && m_ready;
    pop  = r && m_valid;
    @(posedge clk);
    if (pop) begin
      popped = q.pop_front();
      if (popped[6:2] == 5'b00000) begin m_halted = 1'b1; m_drain = 1'b0; end
    end
    if (push) begin
      q.push_back({i[15:11], i[1:0]});
      if (i[15:11] == 5'b00000) m_drain = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'($urandom_range(0, 1));
    op_ready    = 1'($urandom_range(0, 1));
    instr       = 16'($urandom);
    @(posedge clk);
    q.delete(); m_drain = 1'b0; m_halted = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if ({op_valid, halted, ALU_op, ALU_funct, instr_ready} !== 10'b00_00000_00_1) begin
      mismatched++;
      $display("FAIL reset_outputs: got valid=%b halted=%b op=%b funct=%b ready=%b expected 0 0 00000 00 1",
               op_valid, halted, ALU_op, ALU_funct, instr_ready);
    end
    step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_add();
    do_reset();
    step(1'b1, 16'hD800, 1'b0);
    compared++;
    if (op_valid !== 1'b1 || ALU_op !== 5'b11011 || ALU_funct !== 2'b00) begin
      mismatched++;
      $display("FAIL add_latency: got valid=%b op=%b funct=%b expected 1 11011 00", op_valid, ALU_op, ALU_funct);
    end
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b1, 16'h4000, 1'b0);
    step(1'b1, 16'hC000, 1'b0);
    compared++;
    if (instr_ready !== 1'b0) begin
      mismatched++; $display("FAIL bp_full_ready: got %b expected 0", instr_ready);
    end
    step(1'b1, 16'hD800, 1'b0);
    compared++;
    if (ALU_op !== 5'b01000) begin
      mismatched++; $display("FAIL bp_first: got %b expected 01000", ALU_op);
    end
    step(1'b0, 16'h0, 1'b1);
    compared++;
    if (ALU_op !== 5'b11000) begin
      mismatched++; $display("FAIL bp_second: got %b expected 11000", ALU_op);
    end
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 16'hD803, 1'b0);
    step(1'b1, 16'h4001, 1'b0);
    step(1'b1, 16'hC002, 1'b1);
    compared++;
    if (instr_ready !== 1'b1) begin
      mismatched++; $display("FAIL b2b_ready: got %b expected 1", instr_ready);
    end
    for (int k = 0; k < 6; k++) step(1'b1, 16'h4000 | 16'(k), 1'b1);
    compared++;
    if (instr_ready !== 1'b1 || op_valid !== 1'b1) begin
      mismatched++; $display("FAIL b2b_steady: got ready=%b valid=%b expected 1 1", instr_ready, op_valid);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_halt();
    do_reset();
    step(1'b1, 16'h0000, 1'b0);
    compared++;
    if (instr_ready !== 1'b0) begin
      mismatched++; $display("FAIL halt_ready: got %b expected 0", instr_ready);
    end
    step(1'b1, 16'hD800, 1'b1);
    compared++;
    if (halted !== 1'b1 || op_valid !== 1'b0) begin
      mismatched++; $display("FAIL halt_state: got halted=%b valid=%b expected 1 0", halted, op_valid);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_mid_drain_reset();
    do_reset();
    step(1'b1, 16'hD800, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    do_reset();
    compared++;
    if (op_valid !== 1'b0 || halted !== 1'b0 || instr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL drain_reset: got valid=%b halted=%b ready=%b expected 0 0 1", op_valid, halted, instr_ready);
    end
    step(1'b0, 16'h0, 1'b1);
  endtask

`ifdef DECODE_ERR_EN
  task automatic test_decode_err();
    do_reset();
    step(1'b1, 16'hD801, 1'b0);
    compared++;
    if (err !== 1'b1) begin
      mismatched++; $display("FAIL err_unsupported: got %b expected 1", err);
    end
    step(1'b1, 16'hD803, 1'b1);
    compared++;
    if (err !== 1'b0) begin
      mismatched++; $display("FAIL err_andn: got %b expected 0", err);
    end
    step(1'b0, 16'h0, 1'b1);
  endtask
`endif

  task automatic test_random();
    logic [15:0] tbl [8];
    tbl = '{16'hD800, 16'hD803, 16'hD801, 16'h4123, 16'hC0FE, 16'h5555, 16'hAAAA, 16'h0000};
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? tbl[7] : tbl[$urandom_range(0, 6)] ^ 16'($urandom_range(0, 3) << 2),
           1'($urandom_range(0, 2) != 0));
    end
  endtask

  initial begin
    rst_n = 1'b1; instr = '0; instr_valid = 1'b0; op_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_backpressure();
    test_back_to_back();
    test_halt();
    test_mid_drain_reset();
`ifdef DECODE_ERR_EN
    test_decode_err();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: instr  input  16  instruction word from fetch.
REQ-004 SHALL have port: instr_valid  input  1  instr is valid this cycle.
REQ-005 SHALL have port: instr_ready  output  1  block can accept instr this cycle.
REQ-006 SHALL have port: ALU_op  output  5  opcode field issued to ALU control.
REQ-007 SHALL have port: ALU_funct  output  2  function field issued to ALU control.
REQ-008 SHALL have port: op_valid  output  1  ALU_op/ALU_funct valid.
REQ-009 SHALL have port: op_ready  input  1  downstream consumes the issued op.
REQ-010 SHALL have port: halted  output  1  HALT has been issued and consumed.
REQ-011 SHALL have port: err  output  1  issued op is unsupported (present only with DECODE_ERR_EN).
REQ-012 SHALL have parameter: DEPTH, default 2, number of buffer entries (2 or 4).

Function
REQ-013 SHALL transfer an instruction on a cycle with instr_valid && instr_ready high.
REQ-014 SHALL transfer an op on a cycle with op_valid && op_ready high.
REQ-015 SHALL store each accepted instruction as {instr[15:11], instr[1:0]} in a DEPTH-entry FIFO, in order.
REQ-016 SHALL drive ALU_op/ALU_funct from the FIFO head, with op_valid = (count != 0).
REQ-017 SHALL present an instruction accepted into an empty FIFO on the outputs the following cycle (1-cycle latency).
REQ-018 SHALL drive instr_ready = (state == RUN) && (count < DEPTH), using registered count only.
REQ-019 SHALL allow push and pop in the same cycle; count unchanged, pointers each advance.
REQ-020 SHALL wrap read/write pointers modulo DEPTH.
REQ-021 SHALL hold ALU_op/ALU_funct stable while op_valid && !op_ready.
REQ-022 SHALL implement states RUN, DRAIN, HALTED.
REQ-023 SHALL move RUN->DRAIN on accepting an instr with instr[15:11] == 5'b00000 (HALT).
REQ-024 SHALL accept no instruction in DRAIN or HALTED.
REQ-025 SHALL move DRAIN->HALTED on the cycle the HALT op is consumed; halted = 1 from the next cycle.
REQ-026 SHALL remain in HALTED until reset, with op_valid = 0.
REQ-027 SHALL treat as supported: {11011,00} ADD, {11011,11} ANDN, {01000,xx} ADDI, {11000,xx} LBI, {00000,xx} HALT.

Reset
REQ-028 SHALL, with rst_n low at a rising edge, set state = RUN, count = 0, pointers = 0.
REQ-029 SHALL reset outputs to op_valid = 0, halted = 0, err = 0, ALU_op = 5'b00000, ALU_funct = 2'b00.
REQ-030 SHALL ignore instr_valid and op_ready during the reset cycle.
REQ-031 SHALL discard all buffered ops when reset occurs in any state, including DRAIN.

Configuration
REQ-032 SHALL define macro DECODE_ERR_EN to compile in unsupported-op detection.
REQ-033 SHALL, with DECODE_ERR_EN defined, drive err = op_valid && (head not in the REQ-027 set).
REQ-034 SHALL, with DECODE_ERR_EN defined, still issue unsupported ops normally, without stalling.
REQ-035 SHALL, with DECODE_ERR_EN undefined, omit the err port and its logic, and issue all ops unchanged.

Verification
REQ-036 SHALL test ADD: 0xD800 accepted into an empty FIFO -> next cycle ALU_op = 11011, ALU_funct = 00, op_valid = 1.
REQ-037 SHALL test backpressure: op_ready = 0, push 0x4000 then 0xC000 -> instr_ready = 0 after the 2nd push (DEPTH = 2); then op_ready = 1 -> ops 01000, 11000 issued in order.
REQ-038 SHALL test simultaneous push/pop: full FIFO, op_ready = 1 -> count stays DEPTH-1 and instr_ready = 1 the next cycle.
REQ-039 SHALL test HALT: accept 0x0000 -> instr_ready = 0; op_ready = 1 -> halted = 1 the cycle after consumption, op_valid = 0 thereafter.
REQ-040 SHALL test mid-drain reset: rst_n = 0 in DRAIN with 2 ops buffered -> op_valid = 0, halted = 0, instr_ready = 1 the next cycle.
REQ-041 SHALL test DECODE_ERR_EN: issue 0xD801 ({11011,01}) -> err = 1 while it is head; issue 0xD803 -> err = 0.
